// File: rtl/mips_register_file_if.sv
// rtl/mips_register_file_if.sv - Register-file access bundle: write port, two read ports, write counter.
interface mips_register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [7:0]        wr_count;

    modport master (
        output we, wa, wd, ra1, ra2,
        input  rd1, rd2, wr_count
    );

    modport slave (
        input  we, wa, wd, ra1, ra2,
        output rd1, rd2, wr_count
    );
endinterface

// File: rtl/mips_register_file.sv
// rtl/mips_register_file.sv - 32-entry MIPS register file, 2 async reads, 1 sync write, reg 0 hardwired to zero.
// Optional write-through bypass on the read ports: MIPS_REGFILE_BYPASS_EN.
module mips_register_file #(
    parameter int              DATA_W    = 32,
    parameter int              ADDR_W    = 5,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mips_register_file_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [7:0]        wr_count_q;
    logic [7:0]        wr_count_d;
    logic              wr_en;

    assign wr_en = bus.we && (bus.wa != '0);

    always_comb begin
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        if (wr_en) begin
            regs_d[bus.wa] = bus.wd;
            if (wr_count_q != 8'hFF) begin
                wr_count_d = wr_count_q + 8'd1;
            end
        end
        // Entry 0 is kept at zero so the read mux never needs history.
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q[0] <= '0;
            for (int i = 1; i < DEPTH; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            wr_count_q <= 8'd0;
        end else begin
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
        end
    end

    always_comb begin
        bus.rd1 = (bus.ra1 == '0) ? '0 : regs_q[bus.ra1];
`ifdef MIPS_REGFILE_BYPASS_EN
        if (wr_en && (bus.ra1 == bus.wa)) begin
            bus.rd1 = bus.wd;
        end
`endif
    end

    always_comb begin
        bus.rd2 = (bus.ra2 == '0) ? '0 : regs_q[bus.ra2];
`ifdef MIPS_REGFILE_BYPASS_EN
        if (wr_en && (bus.ra2 == bus.wa)) begin
            bus.rd2 = bus.wd;
        end
`endif
    end

    assign bus.wr_count = wr_count_q;
endmodule

// File: tb/tb_mips_register_file.sv
// tb/tb_mips_register_file.sv - Directed self-checking bench for mips_register_file.
module tb_mips_register_file;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    logic [31:0] exp_mem [32];

    mips_register_file_if #(.DATA_W(32), .ADDR_W(5)) rf ();

    mips_register_file #(.DATA_W(32), .ADDR_W(5), .RESET_VAL(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d);
        rf.we = 1'b1;
        rf.wa = a;
        rf.wd = d;
        tick();
        rf.we = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n  = 1'b0;
        rf.we  = 1'b0;
        rf.wa  = '0;
        rf.wd  = '0;
        rf.ra1 = '0;
        rf.ra2 = '0;
        #12;
        check("reset_rd1_a0", rf.rd1, 32'h0);
        rf.ra1 = 5'd5;
        rf.ra2 = 5'd31;
        #1;
        check("reset_rd1_a5", rf.rd1, 32'h0);
        check("reset_rd2_a31", rf.rd2, 32'h0);
        check("reset_wr_count", {24'h0, rf.wr_count}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int a = 1; a < 32; a++) write(5'(a), 32'hFFFFFFFF);
        rf.ra1 = 5'd9;
        #1;
        check("fill_rd1_a9", rf.rd1, 32'hFFFFFFFF);
        check("fill_wr_count", {24'h0, rf.wr_count}, 32'd31);

        // Async reset away from any clock edge must clear everything at once.
        #1;
        rst_n = 1'b0;
        #1;
        for (int a = 0; a < 32; a++) begin
            rf.ra1 = 5'(a);
            rf.ra2 = 5'(31 - a);
            #0.1;
            check("async_reset_rd1", rf.rd1, 32'h0);
            check("async_reset_rd2", rf.rd2, 32'h0);
        end
        check("async_reset_wr_count", {24'h0, rf.wr_count}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        write(5'd5, 32'hDEADBEEF);
        rf.ra1 = 5'd5;
        rf.ra2 = 5'd5;
        #1;
        check("w5_rd1", rf.rd1, 32'hDEADBEEF);
        check("w5_rd2", rf.rd2, 32'hDEADBEEF);
        check("w5_wr_count", {24'h0, rf.wr_count}, 32'd1);

        write(5'd0, 32'h12345678);
        rf.ra1 = 5'd0;
        #1;
        check("w0_rd1", rf.rd1, 32'h0);
        check("w0_wr_count", {24'h0, rf.wr_count}, 32'd1);

        write(5'd7, 32'h11111111);
        rf.ra1 = 5'd7;
        rf.ra2 = 5'd7;
        rf.we  = 1'b1;
        rf.wa  = 5'd7;
        rf.wd  = 32'hA5A5A5A5;
        #1;
`ifdef MIPS_REGFILE_BYPASS_EN
        check("same_cycle_pre_rd1", rf.rd1, 32'hA5A5A5A5);
        check("same_cycle_pre_rd2", rf.rd2, 32'hA5A5A5A5);
`else
        check("same_cycle_pre_rd1", rf.rd1, 32'h11111111);
        check("same_cycle_pre_rd2", rf.rd2, 32'h11111111);
`endif
        tick();
        rf.we = 1'b0;
        check("same_cycle_post_rd1", rf.rd1, 32'hA5A5A5A5);
        check("same_cycle_post_wr_count", {24'h0, rf.wr_count}, 32'd3);

        rf.we  = 1'b1;
        rf.wa  = 5'd0;
        rf.wd  = 32'h55555555;
        rf.ra1 = 5'd0;
        #1;
        check("w0_no_bypass_rd1", rf.rd1, 32'h0);
        tick();
        rf.we = 1'b0;

        rf.wa = 5'd7;
        rf.wd = 32'h0;
        rf.ra1 = 5'd7;
        tick();
        check("we0_hold_rd1", rf.rd1, 32'hA5A5A5A5);
        check("we0_hold_wr_count", {24'h0, rf.wr_count}, 32'd3);

        // Pending write aborted by reset; we drops before the next edge.
        rf.we = 1'b1;
        rf.wa = 5'd3;
        rf.wd = 32'hCAFEF00D;
        #1;
        rst_n = 1'b0;
        #1;
        rf.we = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        rf.ra1 = 5'd7;
        rf.ra2 = 5'd3;
        #1;
        check("reset_abort_rd2_a3", rf.rd2, 32'h0);
        check("reset_abort_rd1_a7", rf.rd1, 32'h0);
        check("reset_abort_wr_count", {24'h0, rf.wr_count}, 32'h0);

        for (int a = 0; a < 32; a++) exp_mem[a] = 32'h0;
        for (int i = 0; i < 300; i++) begin
            logic [4:0]  a;
            logic [31:0] d;
            a = 5'((i % 31) + 1);
            d = 32'h1000_0000 + 32'(i) * 32'h0001_0003;
            exp_mem[a] = d;
            write(a, d);
        end
        for (int a = 1; a < 32; a++) begin
            rf.ra1 = 5'(a);
            rf.ra2 = 5'(32 - a);
            #1;
            check("sat_rd1", rf.rd1, exp_mem[a]);
            check("sat_rd2", rf.rd2, exp_mem[32 - a]);
        end
        rf.ra1 = 5'd0;
        #1;
        check("sat_rd1_a0", rf.rd1, 32'h0);
        check("sat_wr_count", {24'h0, rf.wr_count}, 32'd255);
        write(5'd4, 32'h0BADCAFE);
        rf.ra1 = 5'd4;
        #1;
        check("sat_hold_wr_count", {24'h0, rf.wr_count}, 32'd255);
        check("sat_last_rd1", rf.rd1, 32'h0BADCAFE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
